fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_pkg.sv | 13 +
 rtl/pc_next.sv | 23 ++
 rtl/fetch_unit.sv | 102 ++++++++++
 tb/tb_fetch_unit.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

    localparam int CODE_W = 9;
    localparam logic [CODE_W-1:0] HALT_CODE_DEFAULT = 9'b111111111;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HALT  = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/pc_next.sv
// Next program-counter selection: sequential increment, absolute jump or
// pc-relative jump off the address of the instruction being redirected.
module pc_next #(
    parameter int D = 12
) (
    input  logic [D-1:0] prog_ctr,
    input  logic [D-1:0] instr_pc,
    input  logic [D-1:0] branch_target,
    input  logic         take_branch,
    input  logic         branch_rel,
    output logic [D-1:0] next_pc
);

    // D-bit adds wrap naturally, so negative offsets are plain two's complement
    always_comb begin
        if (take_branch) begin
            next_pc = branch_rel ? (instr_pc + branch_target) : branch_target;
        end else begin
            next_pc = prog_ctr + D'(1);
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: drives the external ROM address and registers the
// returned word with its address, handling stall, branch redirect and halt.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int                D         = 12,
    parameter logic [CODE_W-1:0] HALT_CODE = HALT_CODE_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              stall,
    input  logic              branch_en,
    input  logic              branch_rel,
    input  logic [D-1:0]      branch_target,
    output logic [D-1:0]      prog_ctr,
    input  logic [CODE_W-1:0] mach_code,
    output logic [CODE_W-1:0] instr,
    output logic [D-1:0]      instr_pc,
    output logic              instr_valid,
    output logic              done
);

    fetch_state_t      state_q, state_d;
    logic [D-1:0]      pc_d, instr_pc_d, next_pc;
    logic [CODE_W-1:0] instr_d;
    logic              valid_d, done_d;
    logic              take_branch;

    // A redirect only means something when there is a live instruction to redirect
    assign take_branch = (state_q == FETCH) && branch_en && instr_valid;

    pc_next #(.D(D)) u_pc_next (
        .prog_ctr      (prog_ctr),
        .instr_pc      (instr_pc),
        .branch_target (branch_target),
        .take_branch   (take_branch),
        .branch_rel    (branch_rel),
        .next_pc       (next_pc)
    );

    always_comb begin
        state_d    = state_q;
        pc_d       = prog_ctr;
        instr_d    = instr;
        instr_pc_d = instr_pc;
        valid_d    = instr_valid;
        done_d     = done;
        case (state_q)
            IDLE: begin
                pc_d    = '0;
                valid_d = 1'b0;
                if (start) state_d = FETCH;
            end
            FETCH: begin
                // Branch beats both stall and a halt word arriving on the wrong path
                if (take_branch) begin
                    pc_d    = next_pc;
                    valid_d = 1'b0;
                end else if (!stall) begin
                    if (mach_code == HALT_CODE) begin
                        state_d = HALT;
                        valid_d = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        instr_d    = mach_code;
                        instr_pc_d = prog_ctr;
                        valid_d    = 1'b1;
                        pc_d       = next_pc;
                    end
                end
            end
            HALT: begin
                if (start) begin
                    state_d = FETCH;
                    pc_d    = '0;
                    done_d  = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            prog_ctr    <= '0;
            instr       <= '0;
            instr_pc    <= '0;
            instr_valid <= 1'b0;
            done        <= 1'b0;
        end else begin
            state_q     <= state_d;
            prog_ctr    <= pc_d;
            instr       <= instr_d;
            instr_pc    <= instr_pc_d;
            instr_valid <= valid_d;
            done        <= done_d;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a 12-bit instance for fetch/stall/branch/halt
// and a 4-bit instance for counter wrap and mid-stall reset.
module tb_fetch_unit;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // 12-bit instance and its ROM
    logic        reset, start, stall, branch_en, branch_rel;
    logic [11:0] branch_target, prog_ctr, instr_pc;
    logic [8:0]  mach_code, instr;
    logic        instr_valid, done;
    logic [8:0]  rom [0:4095];

    assign mach_code = rom[prog_ctr];

    fetch_unit dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .stall         (stall),
        .branch_en     (branch_en),
        .branch_rel    (branch_rel),
        .branch_target (branch_target),
        .prog_ctr      (prog_ctr),
        .mach_code     (mach_code),
        .instr         (instr),
        .instr_pc      (instr_pc),
        .instr_valid   (instr_valid),
        .done          (done)
    );

    // 4-bit instance for wrap-around
    logic       reset4, start4, stall4;
    logic [3:0] prog_ctr4, instr_pc4;
    logic [8:0] mach_code4, instr4;
    logic       instr_valid4, done4;
    logic [8:0] rom4 [0:15];

    assign mach_code4 = rom4[prog_ctr4];

    fetch_unit #(.D(4)) dut4 (
        .clk           (clk),
        .reset         (reset4),
        .start         (start4),
        .stall         (stall4),
        .branch_en     (1'b0),
        .branch_rel    (1'b0),
        .branch_target (4'd0),
        .prog_ctr      (prog_ctr4),
        .mach_code     (mach_code4),
        .instr         (instr4),
        .instr_pc      (instr_pc4),
        .instr_valid   (instr_valid4),
        .done          (done4)
    );

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic st, input logic stl, input logic be,
                                 input logic br, input logic [11:0] bt);
        start         = st;
        stall         = stl;
        branch_en     = be;
        branch_rel    = br;
        branch_target = bt;
        @(posedge clk);
        #1;
    endtask

    task automatic checkState(input string tag, input logic [11:0] pc, input logic [8:0] ins,
                              input logic [11:0] ipc, input logic vld, input logic dn);
        checkOutput({tag, ".prog_ctr"},    32'(prog_ctr),    32'(pc));
        checkOutput({tag, ".instr"},       32'(instr),       32'(ins));
        checkOutput({tag, ".instr_pc"},    32'(instr_pc),    32'(ipc));
        checkOutput({tag, ".instr_valid"}, 32'(instr_valid), 32'(vld));
        checkOutput({tag, ".done"},        32'(done),        32'(dn));
    endtask

    initial begin
        for (int a = 0; a < 4096; a++) rom[a] = 9'((a + 1) & 255);
        for (int a = 0; a < 16; a++) rom4[a] = 9'(a + 1);
        reset4 = 1'b1; start4 = 1'b0; stall4 = 1'b0;

        // Reset with start held high: start must be ignored
        reset = 1'b1;
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 12'd0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 12'd0);
        checkState("reset", 12'd0, 9'd0, 12'd0, 1'b0, 1'b0);
        reset = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 12'd0);
        checkState("idle_after_reset", 12'd0, 9'd0, 12'd0, 1'b0, 1'b0);

        // Start and stream addresses 0..3
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 12'd0);
        checkState("start_edge", 12'd0, 9'd0, 12'd0, 1'b0, 1'b0);
        for (int k = 0; k < 4; k++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 12'd0);
            checkState($sformatf("stream%0d", k), 12'(k + 1), 9'(k + 1), 12'(k), 1'b1, 1'b0);
        end
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 12'd0);
        checkState("stream4", 12'd5, 9'd5, 12'd4, 1'b1, 1'b0);

        // Stall three cycles at prog_ctr 5
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 12'd0);
            checkState($sformatf("stall%0d", k), 12'd5, 9'd5, 12'd4, 1'b1, 1'b0);
        end
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 12'd0);
        checkState("resume", 12'd6, 9'd6, 12'd5, 1'b1, 1'b0);

        // Advance until instr_pc is 8, then relative branch by -4
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 12'd0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 12'd0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 12'd0);
        checkState("at_pc8", 12'd9, 9'd9, 12'd8, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 12'hFFC);
        checkState("rel_branch", 12'd4, 9'd9, 12'd8, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 12'd0);
        checkState("after_rel", 12'd5, 9'd5, 12'd4, 1'b1, 1'b0);

        // Absolute branch with stall also high: branch wins
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 12'h020);
        checkState("abs_branch", 12'h020, 9'd5, 12'd4, 1'b0, 1'b0);
        // Branch while instr_valid=0 is ignored; start in FETCH ignored too
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 12'h100);
        checkState("branch_ignored", 12'h021, 9'h021, 12'h020, 1'b1, 1'b0);

        // Halt word at 6; first a branch on the same edge suppresses it
        rom[6] = 9'h1FF;
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 12'd5);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 12'd0);
        checkState("pre_halt", 12'd6, 9'd6, 12'd5, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 12'h010);
        checkState("branch_beats_halt", 12'h010, 9'd6, 12'd5, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 12'd0);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 12'd5);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 12'd0);
        checkState("pre_halt2", 12'd6, 9'd6, 12'd5, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 12'd0);
        checkState("halted", 12'd6, 9'd6, 12'd5, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 12'h003);
        checkState("halt_holds", 12'd6, 9'd6, 12'd5, 1'b0, 1'b1);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 12'd0);
        checkState("restart", 12'd0, 9'd6, 12'd5, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 12'd0);
        checkState("restart_fetch", 12'd1, 9'd1, 12'd0, 1'b1, 1'b0);

        // Reset asserted mid-stall
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 12'd0);
        reset = 1'b1;
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 12'd0);
        checkState("reset_mid_stall", 12'd0, 9'd0, 12'd0, 1'b0, 1'b0);
        reset = 1'b0;

        // 4-bit instance: count through the wrap
        reset4 = 1'b0;
        start4 = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 12'd0);
        start4 = 1'b0;
        for (int k = 0; k < 14; k++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 12'd0);
        checkOutput("d4.pc14", 32'(prog_ctr4), 32'd14);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 12'd0);
        checkOutput("d4.pc15", 32'(prog_ctr4), 32'd15);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 12'd0);
        checkOutput("d4.pc_wrap", 32'(prog_ctr4), 32'd0);
        checkOutput("d4.instr_pc15", 32'(instr_pc4), 32'd15);
        checkOutput("d4.instr16", 32'(instr4), 32'd16);
        stall4 = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 12'd0);
        checkOutput("d4.stall_pc", 32'(prog_ctr4), 32'd0);
        reset4 = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 12'd0);
        checkOutput("d4.rst_pc", 32'(prog_ctr4), 32'd0);
        checkOutput("d4.rst_instr", 32'(instr4), 32'd0);
        checkOutput("d4.rst_instr_pc", 32'(instr_pc4), 32'd0);
        checkOutput("d4.rst_valid", 32'(instr_valid4), 32'd0);
        checkOutput("d4.rst_done", 32'(done4), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
